i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 24, giving the audio sample width per channel.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on each I2S input.
REQ-003 clk  input  1  system clock; single clock domain; all state on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i2s_clk  input  1  external I2S bit clock, asynchronous to clk.
REQ-006 i2s_ws  input  1  word select; 0 = left slot, 1 = right slot.
REQ-007 i2s_data  input  1  serial data, MSB first, launched on i2s_clk falling edge.
REQ-008 audio_left  output  DATA_W  received left sample of the current pair.
REQ-009 audio_right  output  DATA_W  received right sample of the current pair.
REQ-010 out_valid  output  1  pair on audio_left/audio_right is valid.
REQ-011 out_ready  input  1  consumer accepts the pair.
REQ-012 overflow  output  1  one-clk pulse: a completed pair was dropped.

Function
REQ-013 i2s_clk, i2s_ws and i2s_data SHALL each pass through SYNC_STAGES flops before use.
REQ-014 A bit strobe SHALL fire for one clk cycle on each synchronized i2s_clk 0->1 transition; ws and data SHALL be sampled in that cycle.
REQ-015 clk SHALL be at least 4x the i2s_clk frequency; behaviour below that ratio is undefined.
REQ-016 At a strobe where sampled ws differs from the ws of the previous strobe (slot boundary), the sampled data bit SHALL belong to the ending slot (standard I2S one-bit delay).
REQ-017 The ending slot's word SHALL then be committed to the channel given by the previous ws.
REQ-018 The bit counter SHALL restart at 0 for the strobe after the boundary.
REQ-019 Within a slot, bit n (n = 0 at the first strobe after the boundary) SHALL be written to shift-register index DATA_W-1-n for n < DATA_W.
REQ-020 Bits with n >= DATA_W SHALL be ignored, and the counter SHALL saturate without wrapping.
REQ-021 The shift register SHALL clear at slot start, so slots shorter than DATA_W yield MSB-aligned words zero-padded at the LSBs.
REQ-022 State machine: UNSYNC -> (first ws boundary) -> LEFT_WAIT -> (left word committed) -> RIGHT_WAIT -> (right word committed) -> LEFT_WAIT.
REQ-023 Words committed in UNSYNC SHALL be discarded; a right word committed in LEFT_WAIT SHALL be discarded.
REQ-024 A right-word commit in RIGHT_WAIT SHALL complete a pair; if out_valid=0, or out_valid=1 with out_ready=1 in that cycle, the pair SHALL load to the outputs and out_valid SHALL be 1 in the next cycle.
REQ-025 If a pair completes while out_valid=1 and out_ready=0, the new pair SHALL be dropped, outputs SHALL hold, and overflow SHALL pulse for 1 cycle.
REQ-026 out_valid SHALL clear the cycle after out_valid=1 and out_ready=1 unless a new pair loads in that same cycle.
REQ-027 audio_left/audio_right SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 Latency: out_valid SHALL rise exactly one clk after the bit strobe carrying the right slot's boundary.

Reset
REQ-029 While reset_n=0: out_valid=0, overflow=0, audio_left=0, audio_right=0, synchronizers, shift register and counter cleared, state=UNSYNC.
REQ-030 Reset deassertion mid-frame SHALL resume in UNSYNC; the first pair emitted SHALL be the first left-then-right pair fully received after the next ws boundary.

Verification
REQ-031 24-bit slots, left=0xABCDEF, right=0x123456, out_ready=1 -> after the sync frame, out_valid pulses with audio_left=0xABCDEF, audio_right=0x123456.
REQ-032 32-bit slots, left=0xABCDEF plus 8 trailing 1s, right=0x123456 plus 8 trailing 1s -> outputs 0xABCDEF/0x123456; trailing bits ignored.
REQ-033 16-bit slots, left=0x1234, right=0xBEEF -> audio_left=0x123400, audio_right=0xBEEF00.
REQ-034 out_ready=0 over two complete frames -> first pair held stable, overflow pulses once at second pair completion; raising out_ready shows the first pair, then out_valid=0.
REQ-035 Stream starts in a right slot -> no output until a left slot followed by a right slot completes; a partial first frame is never emitted.
REQ-036 reset_n pulsed low mid-left-slot -> outputs zero immediately; next valid pair is the first complete frame after the following ws boundary.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes the external bit clock, word select and data into clk,
// deserializes left/right slots and presents complete pairs on a valid/ready output.
module i2s_rx #(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i2s_clk,
    input  logic              i2s_ws,
    input  logic              i2s_data,
    output logic [DATA_W-1:0] audio_left,
    output logic [DATA_W-1:0] audio_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        UNSYNC     = 2'd0,
        LEFT_WAIT  = 2'd1,
        RIGHT_WAIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   sck_s, ws_s, sd_s;
    logic                   sck_prev;
    logic                   ws_prev;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      shreg;
    logic [DATA_W-1:0]      left_word;

    logic                   strobe_c;
    logic                   boundary_c;
    logic [CNT_W-1:0]       idx_c;
    logic [DATA_W-1:0]      word_c;
    logic                   store_left_c;
    logic                   pair_done_c;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ws_s  = ws_sync[SYNC_STAGES-1];
    assign sd_s  = sd_sync[SYNC_STAGES-1];

    // Input synchronizer chains for the three asynchronous I2S lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync[0] <= i2s_clk;
            ws_sync[0]  <= i2s_ws;
            sd_sync[0]  <= i2s_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i] <= sck_sync[i-1];
                ws_sync[i]  <= ws_sync[i-1];
                sd_sync[i]  <= sd_sync[i-1];
            end
            sck_prev <= sck_s;
        end
    end

    assign strobe_c   = sck_s & ~sck_prev;
    assign boundary_c = strobe_c & (ws_s ^ ws_prev);
    assign idx_c      = CNT_W'(DATA_W - 1) - bit_cnt;

    // Current slot word including the bit sampled this strobe (if still in range)
    always_comb begin
        word_c = shreg;
        if (bit_cnt < CNT_W'(DATA_W)) begin
            word_c[idx_c] = sd_s;
        end
    end

    // Slot deserializer: shift register, bit counter and previous word select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            ws_prev <= 1'b0;
        end else if (strobe_c) begin
            ws_prev <= ws_s;
            if (boundary_c) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else begin
                shreg <= word_c;
                if (bit_cnt != CNT_W'(DATA_W)) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Frame alignment state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNSYNC;
        end else begin
            state <= state_next;
        end
    end

    // Frame alignment next state: decide where the ending slot's word goes
    always_comb begin
        state_next   = state;
        store_left_c = 1'b0;
        pair_done_c  = 1'b0;
        if (boundary_c) begin
            case (state)
                UNSYNC: begin
                    state_next = LEFT_WAIT;
                end
                LEFT_WAIT: begin
                    if (!ws_prev) begin
                        store_left_c = 1'b1;
                        state_next   = RIGHT_WAIT;
                    end
                end
                RIGHT_WAIT: begin
                    if (ws_prev) begin
                        pair_done_c = 1'b1;
                        state_next  = LEFT_WAIT;
                    end else begin
                        store_left_c = 1'b1;
                    end
                end
                default: begin
                    state_next = UNSYNC;
                end
            endcase
        end
    end

    // Pair holding register and output handshake with overflow detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_word   <= '0;
            audio_left  <= '0;
            audio_right <= '0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (store_left_c) begin
                left_word <= word_c;
            end
            if (pair_done_c && (!out_valid || out_ready)) begin
                audio_left  <= left_word;
                audio_right <= word_c;
                out_valid   <= 1'b1;
            end else if (pair_done_c) begin
                overflow <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives an I2S stream (8 clk per bit) and scores received pairs.
module tb_i2s_rx;

    localparam int unsigned DATA_W      = 24;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HALF        = 4;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i2s_clk;
    logic              i2s_ws;
    logic              i2s_data;
    logic [DATA_W-1:0] audio_left;
    logic [DATA_W-1:0] audio_right;
    logic              out_valid;
    logic              out_ready;
    logic              overflow;

    int n_pass  = 0;
    int n_total = 0;
    int ovf_cnt = 0;
    logic last_bit;
    pair_t q[$];

    logic              hold_prev = 1'b0;
    logic [DATA_W-1:0] prev_l;
    logic [DATA_W-1:0] prev_r;
    pair_t             exp_p;

    i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i2s_clk    (i2s_clk),
        .i2s_ws     (i2s_ws),
        .i2s_data   (i2s_data),
        .audio_left (audio_left),
        .audio_right(audio_right),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One I2S bit period: data/ws change with the falling bit clock
    task automatic send_bit(input logic ws, input logic d);
        i2s_clk  = 1'b0;
        i2s_ws   = ws;
        i2s_data = d;
        repeat (HALF) @(posedge clk);
        #1;
        i2s_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    // Data lags ws by one bit: the first bit of a slot carries the previous slot's LSB
    task automatic send_slot(input logic ws, input logic [31:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(ws, last_bit);
            last_bit = word[nbits-1-i];
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits);
        send_slot(1'b0, l, nbits);
        send_slot(1'b1, r, nbits);
    endtask

    // Output monitor: pops the scoreboard on handshakes, checks hold stability, counts overflow
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_prev = 1'b0;
        end else begin
            if (overflow) ovf_cnt++;
            if (hold_prev && out_valid) begin
                check("hold_left", 32'(audio_left), 32'(prev_l));
                check("hold_right", 32'(audio_right), 32'(prev_r));
            end
            if (out_valid && out_ready) begin
                check("pair_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_p = q.pop_front();
                    check("pair_left", 32'(audio_left), 32'(exp_p.l));
                    check("pair_right", 32'(audio_right), 32'(exp_p.r));
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_l    = audio_left;
            prev_r    = audio_right;
        end
    end

    initial begin
        int k;
        reset_n   = 1'b0;
        i2s_clk   = 1'b0;
        i2s_ws    = 1'b0;
        i2s_data  = 1'b0;
        out_ready = 1'b1;
        last_bit  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_left", 32'(audio_left), 32'd0);
        check("rst_right", 32'(audio_right), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 24-bit slots after one discarded sync frame
        send_frame(32'h111111, 32'h222222, 24);
        q.push_back('{24'hABCDEF, 24'h123456});
        send_frame(32'hABCDEF, 32'h123456, 24);

        // 32-bit slots with trailing ones; latency of the previous pair measured meanwhile
        q.push_back('{24'hABCDEF, 24'h123456});
        fork
            send_frame(32'hABCDEFFF, 32'h123456FF, 32);
            begin
                @(posedge i2s_clk);
                k = 0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk);
                    #1;
                    k++;
                    if (out_valid) break;
                end
                check("latency", 32'(k), 32'(SYNC_STAGES + 1));
            end
        join

        // 16-bit slots are MSB-aligned and zero padded
        q.push_back('{24'h123400, 24'hBEEF00});
        send_frame(32'h1234, 32'hBEEF, 16);

        // Backpressure: consume the 16-bit pair, then stall across two frames
        q.push_back('{24'h5A5A5A, 24'hA5A5A5});
        fork
            send_frame(32'h5A5A5A, 32'hA5A5A5, 24);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) break;
                end
                check("bp_first_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        join
        send_frame(32'h0C0C0C, 32'hC0C0C0, 24);
        q.push_back('{24'h3C3C3C, 24'hC3C3C3});
        fork
            send_frame(32'h3C3C3C, 32'hC3C3C3, 24);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk);
                    #1;
                    if (overflow) break;
                end
                check("ovf_pulse", 32'(overflow), 32'd1);
                check("ovf_valid_held", 32'(out_valid), 32'd1);
                check("ovf_left_held", 32'(audio_left), 32'(q[0].l));
                check("ovf_right_held", 32'(audio_right), 32'(q[0].r));
                @(posedge clk);
                #1;
                check("ovf_one_cycle", 32'(overflow), 32'd0);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                check("valid_clears", 32'(out_valid), 32'd0);
            end
        join
        send_slot(1'b0, 32'h0, 24);
        repeat (5) @(posedge clk);
        #1;
        check("bp_queue_drained", 32'(q.size()), 32'd0);
        check("ovf_count", 32'(ovf_cnt), 32'd1);

        // Stream starting in a right slot; hold the resulting pair
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_slot(1'b1, 32'h999999, 24);
        q.push_back('{24'h13579B, 24'h2468AC});
        send_frame(32'h13579B, 32'h2468AC, 24);
        out_ready = 1'b0;
        send_slot(1'b0, 32'h0, 10);
        check("rs_valid", 32'(out_valid), 32'd1);
        check("rs_left", 32'(audio_left), 32'(q[0].l));
        check("rs_right", 32'(audio_right), 32'(q[0].r));

        // Reset mid-left-slot clears outputs at once; held pair is lost
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_left", 32'(audio_left), 32'd0);
        check("mid_rst_right", 32'(audio_right), 32'd0);
        q.delete(0);
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        send_slot(1'b0, 32'h0, 14);
        send_slot(1'b1, 32'h777777, 24);
        q.push_back('{24'h0A0B0C, 24'hD0E0F0});
        send_frame(32'h0A0B0C, 32'hD0E0F0, 24);
        send_slot(1'b0, 32'h0, 24);
        repeat (5) @(posedge clk);
        #1;
        check("final_queue_drained", 32'(q.size()), 32'd0);
        check("final_ovf_count", 32'(ovf_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
